cond_br_op: RTL and testbench

- Conditional-branch control unit. It sits downstream of the integer compare operators and consumes their 1-bit result.
- Accepts a condition token from the predecessor basic block, launches exactly one successor block (true or false path), waits for that block to complete, then signals completion upstream.
- Keeps saturating taken/not-taken statistics and a successor watchdog.

---
 rtl/hdbe_ctrl_pkg.sv | 7 +
 rtl/cond_br_op_sat_counter.sv | 14 +
 rtl/cond_br_op.sv | 65 ++++++
 tb/tb_cond_br_op.sv | 97 +++++++++
 4 files changed

// File: rtl/hdbe_ctrl_pkg.sv
// hdbe_ctrl_pkg: branch-control state encoding and watchdog sizing helper
package hdbe_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, COMPLETE, ERROR} state_t;
  function automatic int wd_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/cond_br_op_sat_counter.sv
// sat_counter: enable-gated up-counter that sticks at all-ones
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             inc,
  output logic [width-1:0] count
);
  always_ff @(posedge clk)
    if (!reset_n) count <= '0;
    else if (enable && inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/cond_br_op.sv
// cond_br_op: conditional-branch controller launching one successor per condition token
module cond_br_op
  import hdbe_ctrl_pkg::*;
#(
  parameter int ParamCntWidth = 16,
  parameter int ParamTimeout  = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic                     in_cond,
  output logic                     in_ready,
  output logic                     true_start,
  input  logic                     true_done,
  output logic                     false_start,
  input  logic                     false_done,
  output logic                     out_done,
  output logic                     busy,
  output logic                     error,
  output logic [ParamCntWidth-1:0] taken_cnt,
  output logic [ParamCntWidth-1:0] not_taken_cnt
);
  localparam int WdW = wd_width(ParamTimeout);
  state_t state, state_n;
  logic cond_q, live, accept, sel_done, timeout;
  logic [WdW-1:0] wd;
  assign live     = enable & reset_n;
  assign in_ready = live & (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign sel_done = cond_q ? true_done : false_done;
  assign timeout  = (ParamTimeout != 0) && (int'(wd) + 1 >= ParamTimeout);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = accept ? LAUNCH : IDLE;
      LAUNCH:   state_n = WAIT;
      WAIT:     state_n = sel_done ? COMPLETE : timeout ? ERROR : WAIT;
      COMPLETE: state_n = IDLE;
      ERROR:    state_n = ERROR;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state  <= IDLE;
      cond_q <= 1'b0;
      wd     <= '0;
    end else if (enable) begin
      state  <= state_n;
      cond_q <= accept ? in_cond : cond_q;
      wd     <= (state == WAIT) ? wd + 1'b1 : '0;
    end
  assign true_start  = live & (state == LAUNCH) & cond_q;
  assign false_start = live & (state == LAUNCH) & ~cond_q;
  assign out_done    = live & (state == COMPLETE);
  assign busy        = state != IDLE;
  assign error       = state == ERROR;
  sat_counter #(.width(ParamCntWidth)) u_taken (
    .clk(clk), .reset_n(reset_n), .enable(enable), .inc(accept & in_cond), .count(taken_cnt)
  );
  sat_counter #(.width(ParamCntWidth)) u_not_taken (
    .clk(clk), .reset_n(reset_n), .enable(enable), .inc(accept & ~in_cond), .count(not_taken_cnt)
  );
endmodule

// File: tb/tb_cond_br_op.sv
// tb_cond_br_op: directed and randomized checks of cond_br_op against a token-level model
module tb_cond_br_op;
  localparam int CW = 2, TO = 8, MAXC = (1 << CW) - 1;
  logic clk = 0, reset_n = 0, enable = 0, in_valid = 0, in_cond = 0, true_done = 0, false_done = 0;
  logic in_ready, true_start, false_start, out_done, busy, error;
  logic [CW-1:0] taken_cnt, not_taken_cnt;
  int errors = 0, checks = 0;
  bit pend, side, fin, err;
  int ec, tc, nc;
  always #5 clk = ~clk;
  cond_br_op #(.ParamCntWidth(CW), .ParamTimeout(TO)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid), .in_cond(in_cond),
    .in_ready(in_ready), .true_start(true_start), .true_done(true_done),
    .false_start(false_start), .false_done(false_done), .out_done(out_done),
    .busy(busy), .error(error), .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit rn, input bit en, input bit v, input bit c, input bit td, input bit fd);
    bit live;
    reset_n = rn; enable = en; in_valid = v; in_cond = c; true_done = td; false_done = fd;
    #1;
    live = rn && en;
    check("in_ready", in_ready, live && !pend && !err);
    check("true_start", true_start, live && pend && !fin && ec == 0 && side);
    check("false_start", false_start, live && pend && !fin && ec == 0 && !side);
    check("out_done", out_done, live && fin);
    if (rn) begin
      check("busy", busy, pend || err);
      check("error", error, err);
      check("taken_cnt", taken_cnt, tc > MAXC ? MAXC : tc);
      check("not_taken_cnt", not_taken_cnt, nc > MAXC ? MAXC : nc);
    end
    if (!rn) begin
      pend = 0; fin = 0; err = 0; ec = 0; tc = 0; nc = 0;
    end else if (en && !err) begin
      if (!pend) begin
        if (v) begin
          pend = 1; side = c; ec = 0; fin = 0;
          if (c) tc++; else nc++;
        end
      end else if (fin) begin
        pend = 0; fin = 0;
      end else if (ec == 0) ec = 1;
      else if (side ? td : fd) fin = 1;
      else if (ec == TO) begin
        err = 1; pend = 0;
      end else ec++;
    end
    @(negedge clk);
  endtask
  task automatic tok(input bit c, input int d);
    step(1, 1, 1, c, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (d - 1) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, c, !c);
    step(1, 1, 0, 0, 0, 0);
  endtask
  initial begin
    repeat (2) step(0, 1, 1, 1, 0, 0);
    tok(1, 3);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (5) tok(1, 1);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (TO) step(1, 1, 0, 0, 0, 0);
    repeat (3) step(1, 1, 1, 1, 1, 1);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (3000)
      step(!(err ? $urandom_range(0, 3) == 0 : $urandom_range(0, 199) == 0),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
